// File: rtl/derandomizer.sv
// Receive-side CCSDS Gold-code derandomizer for QPSK phase indices, with SOF realignment and frame-length check.
// Optional protocol-error counter enabled by defining DERANDOMIZER_ERRCNT_EN.
module derandomizer #(
  parameter int FRAME_LEN = 1024
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic        i_sof,
  input  logic [1:0]  i_sym,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [1:0]  o_sym,
  output logic        o_sof,
  output logic        o_eof,
  output logic [15:0] o_err_cnt
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  localparam logic [17:0] X_INIT   = 18'h00001;
  localparam logic [17:0] Y_INIT   = 18'h3FFFF;
  localparam logic [15:0] LAST_CNT = 16'(FRAME_LEN - 1);

  function automatic logic [17:0] step_x(input logic [17:0] x);
    return {x[7] ^ x[0], x[17:1]};
  endfunction

  function automatic logic [17:0] step_y(input logic [17:0] y);
    return {y[10] ^ y[7] ^ y[5] ^ y[0], y[17:1]};
  endfunction

  state_t      state_q, state_d;
  logic [17:0] x_q, y_q;
  logic [15:0] cnt_q;

  logic        drop;
  logic        accept;
  logic        fwd;
  logic        last;
  logic [17:0] gen_x, gen_y;
  logic        z1, z2;
  logic [1:0]  rot;

  logic        vld_p1;
  logic [1:0]  sym_p1;
  logic        sof_p1;
  logic        eof_p1;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (fwd) begin
      if (i_sof)     state_d = (FRAME_LEN == 1) ? IDLE : ACTIVE;
      else if (last) state_d = IDLE;
    end
  end

  // Handshake decode; drops bypass the output stall so o_ready ignores it then
  always_comb begin
    drop    = (state_q == IDLE) && !i_sof;
    o_ready = drop || !vld_p1 || i_ready;
    accept  = i_valid && o_ready;
    fwd     = accept && !drop;
    last    = (state_q == ACTIVE) && !i_sof && (cnt_q == LAST_CNT);
  end

  // Stage p0: generator realigned to its seed on SOF, so R = 0 for the SOF symbol
  always_comb begin
    gen_x = i_sof ? X_INIT : x_q;
    gen_y = i_sof ? Y_INIT : y_q;
    z1    = gen_x[4] ^ gen_x[6] ^ gen_x[15];
    z2    = gen_y[5] ^ gen_y[6] ^ (^gen_y[15:8]);
    rot   = {z1 ^ z2, gen_x[0] ^ gen_y[0]};
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      x_q   <= X_INIT;
      y_q   <= Y_INIT;
      cnt_q <= '0;
    end else if (fwd) begin
      x_q   <= step_x(gen_x);
      y_q   <= step_y(gen_y);
      cnt_q <= i_sof ? 16'd1 : cnt_q + 16'd1;
    end
  end

  // Stage p1: registered output, held while downstream stalls
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      vld_p1 <= 1'b0;
      sym_p1 <= '0;
      sof_p1 <= 1'b0;
      eof_p1 <= 1'b0;
    end else if (fwd) begin
      vld_p1 <= 1'b1;
      sym_p1 <= i_sym - rot;
      sof_p1 <= i_sof;
      eof_p1 <= last;
    end else if (i_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign o_valid = vld_p1;
  assign o_sym   = sym_p1;
  assign o_sof   = sof_p1;
  assign o_eof   = eof_p1;

`ifdef DERANDOMIZER_ERRCNT_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] err_q;
  logic        err_evt;

  // Short frame (SOF while ACTIVE) or symbol dropped in IDLE
  assign err_evt = accept && (drop || (i_sof && (state_q == ACTIVE)));

  always_ff @(posedge i_clk) begin
    if (i_reset)      err_q <= '0;
    else if (err_evt) err_q <= sat_inc(err_q);
  end

  assign o_err_cnt = err_q;
`else
  assign o_err_cnt = '0;
`endif

endmodule

// File: tb/tb_derandomizer.sv
// Scoreboard bench for derandomizer with FRAME_LEN = 8.
module tb_derandomizer;

  localparam int FL = 8;
`ifdef DERANDOMIZER_ERRCNT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic        i_sof = 1'b0;
  logic [1:0]  i_sym = '0;
  logic        o_valid;
  logic        i_ready = 1'b1;
  logic [1:0]  o_sym;
  logic        o_sof;
  logic        o_eof;
  logic [15:0] o_err_cnt;

  derandomizer #(.FRAME_LEN(FL)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
    .i_sof(i_sof), .i_sym(i_sym), .o_valid(o_valid), .i_ready(i_ready),
    .o_sym(o_sym), .o_sof(o_sof), .o_eof(o_eof), .o_err_cnt(o_err_cnt)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_fail = 0;
  int sof_seen = 0;
  int eof_seen = 0;

  logic [1:0] rtab [16];
  logic [3:0] sb [$];

  bit m_active = 1'b0;
  int m_cnt = 0;
  int m_err = 0;

  // Scoreboard monitor: compare every downstream transfer against the queue
  always @(negedge i_clk) begin
    if (!i_reset && o_valid && i_ready) begin
      logic [3:0] e;
      n_cmp++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL out_unexpected: got sym=%0d sof=%b eof=%b, want no output", o_sym, o_sof, o_eof);
      end else begin
        e = sb.pop_front();
        if ({o_sym, o_sof, o_eof} !== e) begin
          n_fail++;
          $display("FAIL out_sym: got sym=%0d sof=%b eof=%b, want sym=%0d sof=%b eof=%b",
                   o_sym, o_sof, o_eof, e[3:2], e[1], e[0]);
        end
      end
      if (o_sof) sof_seen++;
      if (o_eof) eof_seen++;
    end
  end

  function automatic int exp_err();
    return ERR_EN ? m_err : 0;
  endfunction

  task automatic do_reset();
    i_reset = 1'b1;
    i_valid = 1'b0;
    i_sof   = 1'b0;
    @(posedge i_clk); #1;
    sb.delete();
    m_active = 1'b0;
    m_cnt = 0;
    m_err = 0;
    sof_seen = 0;
    eof_seen = 0;
    @(posedge i_clk); #1;
    i_reset = 1'b0;
  endtask

  task automatic send(input logic [1:0] s, input logic sof);
    int waited = 0;
    i_valid = 1'b1;
    i_sym   = s;
    i_sof   = sof;
    @(negedge i_clk);
    while (!o_ready && waited < 50) begin
      @(negedge i_clk);
      waited++;
    end
    if (!o_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL accept_timeout: got o_ready=%b after %0d cycles, want 1", o_ready, waited);
    end else if (sof) begin
      if (m_active) m_err++;
      sb.push_back({2'(s - rtab[0]), 1'b1, 1'b0});
      m_active = 1'b1;
      m_cnt = 1;
    end else if (m_active) begin
      sb.push_back({2'(s - rtab[m_cnt]), 1'b0, (m_cnt == FL - 1)});
      if (m_cnt == FL - 1) m_active = 1'b0;
      m_cnt++;
    end else begin
      m_err++;
    end
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    i_sof   = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while (sb.size() != 0 && k < 20) begin
      @(negedge i_clk);
      k++;
    end
    @(posedge i_clk); #1;
  endtask

  task automatic test_reset();
    i_valid = 1'b1;
    i_sof   = 1'b1;
    i_sym   = 2'd3;
    @(posedge i_clk); @(posedge i_clk);
    @(negedge i_clk);
    n_cmp += 5;
    if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", o_valid); end
    if (o_sym !== 2'd0) begin n_fail++; $display("FAIL rst_sym: got %0d want 0", o_sym); end
    if ({o_sof, o_eof} !== 2'b00) begin n_fail++; $display("FAIL rst_flags: got %b want 00", {o_sof, o_eof}); end
    if (o_err_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_err: got %0d want 0", o_err_cnt); end
    if (o_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", o_ready); end
    i_valid = 1'b0;
    i_sof   = 1'b0;
    @(posedge i_clk); #1;
    do_reset();
  endtask

  task automatic test_basic();
    do_reset();
    i_ready = 1'b1;
    send(2'd0, 1'b1);
    n_cmp += 3;
    if (o_valid !== 1'b1) begin n_fail++; $display("FAIL basic_lat: got o_valid=%b want 1", o_valid); end
    if (o_sof !== 1'b1) begin n_fail++; $display("FAIL basic_sof: got %b want 1", o_sof); end
    if (o_sym !== 2'd0) begin n_fail++; $display("FAIL basic_sym0: got %0d want 0", o_sym); end
    send(2'd1, 1'b0);
    n_cmp += 2;
    if (o_sym !== 2'd0) begin n_fail++; $display("FAIL basic_sym1: got %0d want 0", o_sym); end
    if (o_sof !== 1'b0) begin n_fail++; $display("FAIL basic_sof1: got %b want 0", o_sof); end
    drain();
  endtask

  task automatic test_loopback();
    logic [1:0] orig;
    do_reset();
    i_ready = 1'b1;
    for (int f = 0; f < 3; f++) begin
      for (int p = 0; p < FL; p++) begin
        orig = 2'($urandom_range(0, 3));
        send(2'(orig + rtab[p]), (p == 0));
      end
    end
    drain();
    n_cmp += 4;
    if (sb.size() != 0) begin n_fail++; $display("FAIL loop_drain: got %0d pending want 0", sb.size()); end
    if (eof_seen != 3) begin n_fail++; $display("FAIL loop_eof: got %0d want 3", eof_seen); end
    if (sof_seen != 3) begin n_fail++; $display("FAIL loop_sof: got %0d want 3", sof_seen); end
    if (o_err_cnt !== 16'd0) begin n_fail++; $display("FAIL loop_err: got %0d want 0", o_err_cnt); end
  endtask

  task automatic test_stall();
    logic [1:0] held_exp;
    do_reset();
    i_ready = 1'b1;
    send(2'd1, 1'b1);
    send(2'd2, 1'b0);
    send(2'd3, 1'b0);
    held_exp = 2'(2'd3 - rtab[2]);
    i_ready = 1'b0;
    i_valid = 1'b1;
    i_sof   = 1'b0;
    i_sym   = 2'd0;
    for (int k = 0; k < 5; k++) begin
      @(negedge i_clk);
      n_cmp += 3;
      if (o_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready: got %b want 0", o_ready); end
      if (o_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid: got %b want 1", o_valid); end
      if (o_sym !== held_exp) begin n_fail++; $display("FAIL stall_sym: got %0d want %0d", o_sym, held_exp); end
      @(posedge i_clk); #1;
    end
    i_ready = 1'b1;
    send(2'd0, 1'b0);
    for (int p = 4; p < FL; p++) send(2'(p), 1'b0);
    drain();
    n_cmp += 2;
    if (sb.size() != 0) begin n_fail++; $display("FAIL stall_drain: got %0d pending want 0", sb.size()); end
    if (eof_seen != 1) begin n_fail++; $display("FAIL stall_eof: got %0d want 1", eof_seen); end
  endtask

  task automatic test_errors();
    logic [1:0] held;
    do_reset();
    i_ready = 1'b1;
    send(2'd2, 1'b1);
    send(2'd1, 1'b0);
    send(2'd3, 1'b0);
    send(2'd3, 1'b1);
    for (int p = 1; p < FL; p++) send(2'(p + 1), 1'b0);
    i_ready = 1'b0;
    @(negedge i_clk);
    held = o_sym;
    n_cmp++;
    if (o_ready !== 1'b1) begin n_fail++; $display("FAIL drop_ready: got %b want 1", o_ready); end
    @(posedge i_clk); #1;
    send(2'd1, 1'b0);
    n_cmp++;
    if (o_valid !== 1'b1 || o_sym !== held) begin
      n_fail++;
      $display("FAIL drop_hold: got valid=%b sym=%0d want valid=1 sym=%0d", o_valid, o_sym, held);
    end
    i_ready = 1'b1;
    send(2'd3, 1'b0);
    drain();
    n_cmp += 4;
    if (sb.size() != 0) begin n_fail++; $display("FAIL err_drain: got %0d pending want 0", sb.size()); end
    if (eof_seen != 1) begin n_fail++; $display("FAIL err_eof: got %0d want 1", eof_seen); end
    if (sof_seen != 2) begin n_fail++; $display("FAIL err_sof: got %0d want 2", sof_seen); end
    if (o_err_cnt !== 16'(exp_err())) begin
      n_fail++;
      $display("FAIL err_cnt: got %0d want %0d", o_err_cnt, exp_err());
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    i_ready = 1'b1;
    send(2'd1, 1'b1);
    send(2'd2, 1'b0);
    send(2'd3, 1'b0);
    send(2'd0, 1'b0);
    i_reset = 1'b1;
    @(posedge i_clk); #1;
    n_cmp++;
    if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b want 0", o_valid); end
    do_reset();
    send(2'd2, 1'b1);
    n_cmp += 3;
    if (o_sym !== 2'd2) begin n_fail++; $display("FAIL rstmid_sym: got %0d want 2", o_sym); end
    if (o_sof !== 1'b1) begin n_fail++; $display("FAIL rstmid_sof: got %b want 1", o_sof); end
    if (o_err_cnt !== 16'd0) begin n_fail++; $display("FAIL rstmid_err: got %0d want 0", o_err_cnt); end
    drain();
  endtask

  initial begin
    logic [17:0] gx, gy;
    gx = 18'h00001;
    gy = 18'h3FFFF;
    for (int i = 0; i < 16; i++) begin
      rtab[i] = {(gx[4] ^ gx[6] ^ gx[15]) ^ (gy[5] ^ gy[6] ^ gy[8] ^ gy[9] ^ gy[10] ^ gy[11] ^
                  gy[12] ^ gy[13] ^ gy[14] ^ gy[15]), gx[0] ^ gy[0]};
      gx = {gx[7] ^ gx[0], gx[17:1]};
      gy = {gy[10] ^ gy[7] ^ gy[5] ^ gy[0], gy[17:1]};
    end
    test_reset();
    test_basic();
    test_loopback();
    test_stall();
    test_errors();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
